// File: rtl/vga_bram_arbiter.sv
// rtl/vga_bram_arbiter.sv - shares one framebuffer BRAM port between VGA scan-out reads and a buffered pixel writer
module vga_bram_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WFIFO_DEPTH = 4,
  parameter int STARVE_MAX  = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           vga_addr,
  input  logic                        vga_en,
  output logic [DATA_W-1:0]           vga_dout,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [DATA_W/8-1:0]         wr_be,
  input  logic [DATA_W-1:0]           bram_dout,
  output logic [ADDR_W-1:0]           bram_addr,
  output logic [DATA_W-1:0]           bram_din,
  output logic [DATA_W/8-1:0]         bram_we,
  output logic                        bram_en,
  output logic [$clog2(WFIFO_DEPTH):0] wr_pending,
  output logic                        wr_starved
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(WFIFO_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [BE_W-1:0]   fifo_be   [WFIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  starve_cnt;
  logic [SC_W-1:0]  starve_next;
  logic             starved;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  // Readiness comes from registered occupancy only, so a same-cycle pop never frees a slot.
  assign wr_ready   = !reset && !full;
  assign push       = wr_valid && wr_ready;
  assign pop        = !reset && !vga_en && !empty;
  assign vga_dout   = bram_dout;
  assign wr_pending = count;
  assign wr_starved = starved;

  // VGA always wins the port; the FIFO head only gets cycles the scan-out leaves idle.
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = '0;
    bram_addr = '0;
    bram_din  = '0;
    if (!reset) begin
      if (vga_en) begin
        bram_en   = 1'b1;
        bram_addr = vga_addr;
      end else if (!empty) begin
        bram_en   = 1'b1;
        bram_we   = fifo_be[rd_ptr];
        bram_addr = fifo_addr[rd_ptr];
        bram_din  = fifo_data[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
      fifo_be[wr_ptr]   <= wr_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    starve_next = starve_cnt;
    if (pop) begin
      starve_next = '0;
    end else if (vga_en && !empty && starve_cnt != STARVE_LIM) begin
      starve_next = starve_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      starved    <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      if (starve_next == STARVE_LIM) starved <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_bram_arbiter.sv
// tb/tb_vga_bram_arbiter.sv - directed and random checks of vga_bram_arbiter against a queue-based model
module tb_vga_bram_arbiter;

  localparam int DEPTH = 4;
  localparam int SMAX  = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] vga_addr;
  logic        vga_en;
  logic [31:0] vga_dout;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] bram_dout = '0;
  logic [31:0] bram_addr;
  logic [31:0] bram_din;
  logic [3:0]  bram_we;
  logic        bram_en;
  logic [2:0]  wr_pending;
  logic        wr_starved;

  int checks = 0;
  int failures = 0;

  ent_t        q[$];
  int          sc = 0;
  logic        starved_m = 1'b0;
  logic [31:0] exp_dout = '0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] env_mem [logic [31:0]];

  vga_bram_arbiter #(
    .ADDR_W(32), .DATA_W(32), .WFIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_addr(vga_addr), .vga_en(vga_en), .vga_dout(vga_dout),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .bram_dout(bram_dout),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .bram_en(bram_en), .wr_pending(wr_pending), .wr_starved(wr_starved)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Synchronous BRAM with read-before-write, driven by whatever the DUT issues.
  always @(posedge clk) begin
    if (bram_en) begin
      logic [31:0] old;
      old = env_mem.exists(bram_addr) ? env_mem[bram_addr] : 32'h0;
      bram_dout <= old;
      env_mem[bram_addr] = merge(old, bram_din, bram_we);
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic [31:0] e_addr, e_din, old;
    logic [3:0]  e_we;
    logic        e_en, e_ready, from_fifo, do_pop, do_push;
    int          n0;
    #1;
    n0        = q.size();
    e_ready   = !reset && (n0 < DEPTH);
    e_en      = 1'b0;
    e_we      = '0;
    e_addr    = '0;
    e_din     = '0;
    from_fifo = 1'b0;
    if (!reset) begin
      if (vga_en) begin
        e_en = 1'b1;
        e_addr = vga_addr;
      end else if (n0 > 0) begin
        e_en = 1'b1;
        e_we = q[0].be;
        e_addr = q[0].addr;
        e_din = q[0].data;
        from_fifo = 1'b1;
      end
    end
    chk("wr_ready", 64'(wr_ready), 64'(e_ready));
    chk("bram_en", 64'(bram_en), 64'(e_en));
    chk("bram_we", 64'(bram_we), 64'(e_we));
    chk("bram_addr", 64'(bram_addr), 64'(e_addr));
    if (from_fifo || reset) chk("bram_din", 64'(bram_din), 64'(e_din));
    chk("wr_pending", 64'(wr_pending), 64'(n0));
    chk("wr_starved", 64'(wr_starved), 64'(starved_m));
    chk("vga_dout", 64'(vga_dout), 64'(exp_dout));
    @(posedge clk);
    if (reset) begin
      q.delete();
      sc = 0;
      starved_m = 1'b0;
    end else begin
      do_pop  = !vga_en && n0 > 0;
      do_push = wr_valid && n0 < DEPTH;
      if (e_en) begin
        old = ref_mem.exists(e_addr) ? ref_mem[e_addr] : 32'h0;
        exp_dout = old;
        ref_mem[e_addr] = merge(old, e_din, e_we);
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{wr_addr, wr_data, wr_be});
      if (do_pop) sc = 0;
      else if (vga_en && n0 > 0 && sc < SMAX) sc++;
      if (sc == SMAX) starved_m = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic set_in(logic rst, logic ven, logic [31:0] va, logic wv,
                        logic [31:0] wa, logic [31:0] wd, logic [3:0] be);
    reset = rst; vga_en = ven; vga_addr = va;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = be;
  endtask

  initial begin
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 32'h1111_1111, 4'hF);
    @(negedge clk);
    // Reset held with a writer knocking
    repeat (3) cycle();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    // VGA-only reads
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 32'(4 * i), 1'b0, 32'h0, 32'h0, 4'h0);
      cycle();
    end
    // Single write into an idle port
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    cycle();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) cycle();
    set_in(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) cycle();
    // Contention: five pushes while VGA owns the port, then drain
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b1, 32'(8 * i), 1'b1, 32'(32'h200 + 4 * i), 32'(32'hA000 + i), 4'hF);
      cycle();
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (5) cycle();
    // Push+pop at occupancy 2
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 1'b1, 32'h0, 1'b1, 32'(32'h300 + 4 * i), 32'(32'hB000 + i), 4'h3);
      cycle();
    end
    for (int i = 2; i < 8; i++) begin
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'(32'h300 + 4 * i), 32'(32'hB000 + i), 4'(i));
      cycle();
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) cycle();
    // Starvation: one pending write blocked for SMAX cycles, flag sticky after drain
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    set_in(1'b0, 1'b1, 32'h10, 1'b1, 32'h400, 32'hC0DE_0001, 4'hF);
    cycle();
    set_in(1'b0, 1'b1, 32'h14, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (SMAX) cycle();
    chk("starve_set", 64'(wr_starved), 64'(1));
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (4) cycle();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    // Random traffic with a reset dropped into the middle of a burst
    for (int i = 0; i < 400; i++) begin
      logic ven;
      ven = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      set_in(i == 237, ven, 32'($urandom_range(0, 15) << 2), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 15) << 2), $urandom, 4'($urandom_range(0, 15)));
      cycle();
    end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      vga_addr = 32'(4 * i);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
